// File: rtl/bus_master_pkg.sv
// Shared types and constants for the bus_master block: FSM state encoding,
// command encodings and the data path width.
package bus_master_pkg;

  localparam int   DATA_W    = 32;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    WAIT_LOW,
    CAPTURE,
    RELEASE
  } state_e;

endpackage

// File: rtl/bus_master_ack.sv
// ack_sync: SYNC_STAGES-deep flop chain bringing the asynchronous slave ack into clk.
// Latency SYNC_STAGES cycles; no backpressure.
module ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bus_master.sv
// Four-phase request/ack master: one host transfer at a time, host_ready only in IDLE,
// host_done pulses on completion. Define TIMEOUT_EN to abort stalled handshakes with host_err.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  input  logic              host_cmd,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              master_req,
  output logic              master_cmd,
  output logic [DATA_W-1:0] master_wdata,
  input  logic              slave_ack,
  input  logic [DATA_W-1:0] slave_rdata
);

  if (TIMEOUT_CYCLES < 1 || SYNC_STAGES < 1) begin : g_bad_params
    $error("bus_master: TIMEOUT_CYCLES and SYNC_STAGES must be >= 1");
  end

  state_e            state_q;
  logic              ack;
  logic              req_q;
  logic              cmd_q;
  logic              done_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (slave_ack),
    .q   (ack)
  );

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout;

  // Counter starts at 0 on the first WAIT_ACK cycle, so this is the last waiting cycle.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cmd_q   <= CMD_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
`ifdef TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TIMEOUT_EN
      err_q  <= 1'b0;
      cnt_q  <= (state_q == WAIT_ACK || state_q == WAIT_LOW) ? cnt_q + 1'b1 : '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (host_valid) begin
            cmd_q   <= host_cmd;
            wdata_q <= host_wdata;
            req_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!ack) begin
            if (cmd_q == CMD_WRITE) begin
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= RELEASE;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          rdata_q <= slave_rdata;
          req_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RELEASE;
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef TIMEOUT_EN
      // Overrides the case above only when the handshake made no progress this cycle.
      if (timeout && ((state_q == WAIT_ACK && !ack) || (state_q == WAIT_LOW && ack))) begin
        req_q   <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
        state_q <= RELEASE;
      end
`endif
    end
  end

  assign host_ready   = (state_q == IDLE);
  assign host_done    = done_q;
  assign host_rdata   = rdata_q;
  assign master_req   = req_q;
  assign master_cmd   = cmd_q;
  assign master_wdata = wdata_q;
`ifdef TIMEOUT_EN
  assign host_err     = err_q;
`else
  assign host_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master with a delayed-ack slave model.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_cmd = 1'b0;
  logic [31:0] host_wdata = '0;
  logic        host_ready, host_done, host_err;
  logic [31:0] host_rdata;
  logic        master_req, master_cmd;
  logic [31:0] master_wdata;
  logic        slave_ack = 1'b0;
  logic [31:0] slave_rdata = '0;

  bus_master #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_valid   (host_valid),
    .host_cmd     (host_cmd),
    .host_wdata   (host_wdata),
    .host_ready   (host_ready),
    .host_done    (host_done),
    .host_rdata   (host_rdata),
    .host_err     (host_err),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_wdata (master_wdata),
    .slave_ack    (slave_ack),
    .slave_rdata  (slave_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave: acks 5 cycles after each req rise, holds ack 3 cycles, presents rdata as ack falls.
  bit          slave_en = 1'b1;
  logic [31:0] slave_val = '0;
  int          sl_cnt = 0;
  logic        sl_req_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      sl_cnt    = 0;
      slave_ack = 1'b0;
    end else begin
      if (master_req && !sl_req_prev && slave_en) sl_cnt = 1;
      else if (sl_cnt != 0) sl_cnt++;
      if (sl_cnt == 6) begin
        slave_ack   = 1'b1;
        slave_rdata = ~slave_val;
      end
      if (sl_cnt == 9) begin
        slave_ack   = 1'b0;
        slave_rdata = slave_val;
        sl_cnt      = 0;
      end
    end
    sl_req_prev = master_req;
  end

  // Event counters, sampled 1ns after each rising edge.
  int          cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, req_rise = 0;
  int          early_drop = 0, unstable = 0, low_run = 1000, min_gap = 1000;
  int          rise_cyc = 0, done_cyc = 0;
  logic        req_prev_m = 1'b0, hold_cmd = 1'b0;
  logic [31:0] hold_wd = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (host_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (host_err) err_cnt++;
    if (host_done && host_err) both_cnt++;
    if (master_req && !req_prev_m) begin
      req_rise++;
      rise_cyc = cyc;
      if (low_run < min_gap) min_gap = low_run;
    end
    if (!master_req && req_prev_m && slave_ack) early_drop++;
    if (master_req && req_prev_m && (master_wdata != hold_wd || master_cmd != hold_cmd)) unstable++;
    hold_wd    = master_wdata;
    hold_cmd   = master_cmd;
    low_run    = master_req ? 0 : low_run + 1;
    req_prev_m = master_req;
  end

  task automatic start_xfer(input logic cmd, input logic [31:0] wd);
    @(negedge clk);
    for (int i = 0; i < 100 && !host_ready; i++) @(negedge clk);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_wdata = wd;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (host_done) seen = 1'b1;
    end
  endtask

  bit seen;
  int d0, e0, r0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(host_ready), 1);
    chk("rst_req", 32'(master_req), 0);
    chk("rst_cmd", 32'(master_cmd), 0);
    chk("rst_wdata", master_wdata, 32'h0);
    chk("rst_rdata", host_rdata, 32'h0);
    chk("rst_done_err", 32'({host_done, host_err}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write with delayed ack
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(1'b1, 32'hDEADBEEF);
    chk("wr_cmd", 32'(master_cmd), 1);
    wait_done(seen);
    chk("wr_done_seen", 32'(seen), 1);
    chk("wr_err_at_done", 32'(host_err), 0);
    chk("wr_req_low_at_done", 32'(master_req), 0);
    repeat (10) @(negedge clk);
    chk("wr_done_once", done_cnt - d0, 1);
    chk("wr_no_err", err_cnt - e0, 0);
    chk("wr_wdata_stable", unstable, 0);
    chk("wr_req_until_ack_low", early_drop, 0);
    chk("wr_wdata", master_wdata, 32'hDEADBEEF);

    // Read, then a write that must not disturb host_rdata
    slave_val = 32'h12345678;
    start_xfer(1'b0, 32'h0);
    wait_done(seen);
    chk("rd_done_seen", 32'(seen), 1);
    chk("rd_rdata", host_rdata, 32'h12345678);
    chk("rd_err", 32'(host_err), 0);
    slave_val = 32'h99990000;
    start_xfer(1'b1, 32'hA5A5A5A5);
    wait_done(seen);
    chk("wr2_done_seen", 32'(seen), 1);
    chk("wr2_rdata_kept", host_rdata, 32'h12345678);

    // Back-to-back: host_valid held for three transfers
    repeat (4) @(negedge clk);
    min_gap = 1000; d0 = done_cnt; r0 = req_rise;
    host_valid = 1'b1; host_cmd = 1'b1; host_wdata = 32'h11110000;
    for (int i = 0; i < 300 && (done_cnt - d0) < 3; i++) @(negedge clk);
    host_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 3);
    chk("b2b_req_count", req_rise - r0, 3);
    chk("b2b_gap_ge1", 32'(min_gap >= 1), 1);

    // host_valid with a read command during WAIT_ACK/WAIT_LOW is ignored
    d0 = done_cnt; r0 = req_rise;
    start_xfer(1'b1, 32'h5555AAAA);
    for (int i = 0; i < 50 && !slave_ack; i++) @(negedge clk);
    host_valid = 1'b1; host_cmd = 1'b0; host_wdata = 32'h0BAD0BAD;
    wait_done(seen);
    host_valid = 1'b0;
    chk("ign_done_seen", 32'(seen), 1);
    repeat (20) @(negedge clk);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_req_count", req_rise - r0, 1);
    chk("ign_cmd_stable", unstable, 0);
    chk("ign_cmd", 32'(master_cmd), 1);
    chk("ign_rdata", host_rdata, 32'h12345678);

    // Reset during WAIT_ACK
    d0 = done_cnt;
    start_xfer(1'b1, 32'h77778888);
    @(negedge clk);
    chk("rst_mid_req_before", 32'(master_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req_async", 32'(master_req), 0);
    chk("rst_mid_ready", 32'(host_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    slave_val = 32'hCAFEF00D;
    start_xfer(1'b0, 32'h0);
    wait_done(seen);
    chk("post_rst_done_seen", 32'(seen), 1);
    chk("post_rst_rdata", host_rdata, 32'hCAFEF00D);
    chk("post_rst_err", 32'(host_err), 0);

`ifdef TIMEOUT_EN
    // Slave never acks
    repeat (4) @(negedge clk);
    slave_en = 1'b0; d0 = both_cnt;
    start_xfer(1'b1, 32'h0F0F0F0F);
    wait_done(seen);
    chk("to_done_seen", 32'(seen), 1);
    chk("to_err_with_done", 32'(host_err), 1);
    chk("to_req_low", 32'(master_req), 0);
    chk("to_latency_le18", 32'((done_cyc - rise_cyc) <= 18), 1);
    chk("to_rdata_kept", host_rdata, 32'hCAFEF00D);
    repeat (4) @(negedge clk);
    chk("to_pulse_once", both_cnt - d0, 1);
    slave_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
